// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: steps a single-cycle RISC-V core one instruction at a time.
// After each step it waits for the datapath to settle, then captures pc/ins/wb
// as a trace record and hands it out on a valid/ready port.
// Ports:
//   clk, rst_n (async, active low)
//   start, entry_point, max_instr, abort : run control
//   int_o, entry_o, step_o               : core INT, entryPoint and clock-enable
//   pc_i, ins_i, wb_i                    : core state to trace
//   trace_valid/ready, trace_pc/ins/wb   : trace record port
//   busy, done, retired                  : run status
// Optional feature: `define HALT_ON_EBREAK_EN ends the run after an ebreak record.
module cpu_run_ctrl #(
  parameter int CNT_W      = 16,
  parameter int SETTLE_CYC = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      entry_point,
  input  logic [CNT_W-1:0] max_instr,
  input  logic             abort,
  output logic             int_o,
  output logic [31:0]      entry_o,
  output logic             step_o,
  input  logic [31:0]      pc_i,
  input  logic [31:0]      ins_i,
  input  logic [31:0]      wb_i,
  output logic             trace_valid,
  input  logic             trace_ready,
  output logic [31:0]      trace_pc,
  output logic [31:0]      trace_ins,
  output logic [31:0]      trace_wb,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_STEP,
    S_SETTLE,
    S_REPORT,
    S_DONE
  } state_e;

  localparam logic [7:0] SETTLE_INIT = 8'(SETTLE_CYC - 1);

  state_e           state_q, state_d;
  logic [31:0]      entry_q, entry_d;
  logic [CNT_W-1:0] max_q, max_d;
  logic [CNT_W-1:0] ret_q, ret_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             first_q, first_d;
  logic             valid_q, valid_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      ins_q, ins_d;
  logic [31:0]      wb_q, wb_d;

  logic [CNT_W-1:0] ret_inc;
  logic             last;
  logic             is_ebreak;

  // Saturate so the count can never wrap past the run length.
  assign ret_inc = (ret_q == max_q) ? ret_q : ret_q + CNT_W'(1);
  assign last    = (ret_inc == max_q);

`ifdef HALT_ON_EBREAK_EN
  assign is_ebreak = (ins_q == 32'h0010_0073);
`else
  assign is_ebreak = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    entry_d = entry_q;
    max_d   = max_q;
    ret_d   = ret_q;
    cnt_d   = cnt_q;
    first_d = first_q;
    valid_d = valid_q;
    pc_d    = pc_q;
    ins_d   = ins_q;
    wb_d    = wb_q;
    int_o   = 1'b0;
    step_o  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          entry_d = entry_point;
          max_d   = max_instr;
          ret_d   = '0;
          first_d = 1'b1;
          state_d = (max_instr == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        int_o   = 1'b1;
        state_d = abort ? S_DONE : S_STEP;
      end
      S_STEP: begin
        step_o = 1'b1;
        // INT stays up through the first step so the core loads entryPoint.
        int_o  = first_q;
        if (abort) begin
          state_d = S_DONE;
        end else begin
          first_d = 1'b0;
          cnt_d   = SETTLE_INIT;
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (abort) begin
          state_d = S_DONE;
        end else if (cnt_q == 8'd0) begin
          pc_d    = pc_i;
          ins_d   = ins_i;
          wb_d    = wb_i;
          valid_d = 1'b1;
          state_d = S_REPORT;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_REPORT: begin
        // Abort wins over a same-cycle handshake: the record is dropped.
        if (abort) begin
          valid_d = 1'b0;
          state_d = S_DONE;
        end else if (trace_ready) begin
          valid_d = 1'b0;
          ret_d   = ret_inc;
          state_d = (last || is_ebreak) ? S_DONE : S_STEP;
        end
      end
      S_DONE: begin
        if (!start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      entry_q <= '0;
      max_q   <= '0;
      ret_q   <= '0;
      cnt_q   <= '0;
      first_q <= 1'b0;
      valid_q <= 1'b0;
      pc_q    <= '0;
      ins_q   <= '0;
      wb_q    <= '0;
    end else begin
      state_q <= state_d;
      entry_q <= entry_d;
      max_q   <= max_d;
      ret_q   <= ret_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
      valid_q <= valid_d;
      pc_q    <= pc_d;
      ins_q   <= ins_d;
      wb_q    <= wb_d;
    end
  end

  assign entry_o     = entry_q;
  assign trace_valid = valid_q;
  assign trace_pc    = pc_q;
  assign trace_ins   = ins_q;
  assign trace_wb    = wb_q;
  assign retired     = ret_q;
  assign done        = (state_q == S_DONE);
  assign busy        = (state_q != S_IDLE) && (state_q != S_DONE);

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl: scoreboard bench for cpu_run_ctrl.
// A tiny core model reacts to step_o; expected records/run totals are queued.
module tb_cpu_run_ctrl;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
    logic [31:0] wb;
  } rec_t;

  typedef struct packed {
    logic [15:0] ret;
    logic [15:0] steps;
    logic [15:0] ints;
  } run_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] entry_point = '0;
  logic [15:0] max_instr = '0;
  logic        abort = 1'b0;
  logic        int_o, step_o;
  logic [31:0] entry_o;
  logic [31:0] pc_i, ins_i, wb_i;
  logic        trace_valid;
  logic        trace_ready = 1'b0;
  logic [31:0] trace_pc, trace_ins, trace_wb;
  logic        busy, done;
  logic [15:0] retired;

  logic [31:0] pc_m;
  logic [31:0] ebreak_pc = 32'hFFFF_FFFF;

  rec_t exp_q[$];
  run_t run_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  logic [15:0] steps = '0;
  logic [15:0] ints = '0;
  logic        done_p = 1'b0;

  cpu_run_ctrl #(.CNT_W(16), .SETTLE_CYC(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .entry_point(entry_point), .max_instr(max_instr),
    .abort(abort), .int_o(int_o), .entry_o(entry_o),
    .step_o(step_o), .pc_i(pc_i), .ins_i(ins_i), .wb_i(wb_i),
    .trace_valid(trace_valid), .trace_ready(trace_ready),
    .trace_pc(trace_pc), .trace_ins(trace_ins),
    .trace_wb(trace_wb), .busy(busy), .done(done),
    .retired(retired)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_m <= '0;
    else if (step_o) pc_m <= int_o ? entry_o : pc_m + 32'd4;
  end

  assign pc_i  = pc_m;
  assign ins_i = (pc_m == ebreak_pc) ? 32'h0010_0073
                                     : {pc_m[15:0], 16'h0013};
  assign wb_i  = pc_m + 32'h1000;

  task automatic chk(string name, logic [159:0] act, logic [159:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (start && !busy && !done) begin
        steps = '0;
        ints  = '0;
      end else begin
        steps = steps + 16'(step_o);
        ints  = ints + 16'(int_o);
      end
      if (trace_valid) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL trace_unexpected: got pc %0h", trace_pc);
        end else if ({trace_pc, trace_ins, trace_wb} !== exp_q[0]
                     || step_o !== 1'b0) begin
          n_fail++;
          $display("FAIL trace_rec: got %0h/%0h/%0h step %0b want %0h",
                   trace_pc, trace_ins, trace_wb, step_o, exp_q[0]);
        end
        if (trace_ready && exp_q.size() != 0) void'(exp_q.pop_front());
      end
      if (done && !done_p) begin
        n_chk++;
        if (run_q.size() == 0) begin
          n_fail++;
          $display("FAIL run_unexpected: retired %0d", retired);
        end else begin
          if ({retired, steps, ints} !== run_q[0]) begin
            n_fail++;
            $display("FAIL run_end: got ret %0d steps %0d ints %0d want %0h",
                     retired, steps, ints, run_q[0]);
          end
          void'(run_q.pop_front());
        end
      end
      done_p = done;
    end else begin
      done_p = 1'b0;
    end
  end

  task automatic start_run(logic [31:0] ep, logic [15:0] mx);
    @(posedge clk); #1;
    entry_point = ep;
    max_instr   = mx;
    start       = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(string name);
    int k;
    for (k = 0; k < 200; k++) begin
      if (done) break;
      @(posedge clk); #1;
    end
    if (!done) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: timeout waiting for done", name);
    end
  endtask

  task automatic push_rec(logic [31:0] pc, logic [31:0] ins, logic [31:0] wb);
    rec_t r;
    r.pc = pc; r.ins = ins; r.wb = wb;
    exp_q.push_back(r);
  endtask

  task automatic push_run(logic [15:0] r, logic [15:0] s, logic [15:0] i);
    run_t e;
    e.ret = r; e.steps = s; e.ints = i;
    run_q.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sc;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outs", {int_o, entry_o, step_o, trace_valid, trace_pc,
        trace_ins, trace_wb, busy, done, retired}, '0);
    rst_n = 1'b1;

    // 1: three instructions from 0x28, ready tied high
    trace_ready = 1'b1;
    push_rec(32'h28, 32'h0028_0013, 32'h1028);
    push_rec(32'h2C, 32'h002C_0013, 32'h102C);
    push_rec(32'h30, 32'h0030_0013, 32'h1030);
    push_run(16'd3, 16'd3, 16'd2);
    start_run(32'h28, 16'd3);
    chk("t1_load", {int_o, step_o, busy, entry_o}, {3'b101, 32'h28});
    @(posedge clk); #1;
    chk("t1_first_step", {int_o, step_o}, 2'b11);
    @(posedge clk); #1;
    chk("t1_settle_int", {int_o, step_o}, 2'b00);
    wait_done("t1");
    chk("t1_retired", {done, busy, retired}, {2'b10, 16'd3});

    // 2: consumer stalls five cycles on the first record
    trace_ready = 1'b0;
    push_rec(32'h40, 32'h0040_0013, 32'h1040);
    push_rec(32'h44, 32'h0044_0013, 32'h1044);
    push_run(16'd2, 16'd2, 16'd2);
    start_run(32'h40, 16'd2);
    for (int k = 0; k < 20 && !trace_valid; k++) begin
      @(posedge clk); #1;
    end
    chk("t2_valid", trace_valid, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    chk("t2_stall_retired", {trace_valid, retired}, {1'b1, 16'd0});
    trace_ready = 1'b1;
    wait_done("t2");
    chk("t2_retired", retired, 16'd2);

    // 3: zero-length run
    push_run(16'd0, 16'd0, 16'd0);
    start_run(32'h77, 16'd0);
    chk("t3_done_next", {done, busy, retired}, {2'b10, 16'd0});

    // 4: abort in SETTLE of the second instruction
    push_rec(32'h80, 32'h0080_0013, 32'h1080);
    push_run(16'd1, 16'd2, 16'd2);
    start_run(32'h80, 16'd5);
    sc = 0;
    for (int k = 0; k < 40 && sc < 2; k++) begin
      @(posedge clk); #1;
      if (step_o) sc++;
    end
    chk("t4_second_step", sc, 2);
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("t4_abort", {done, trace_valid, retired}, {2'b10, 16'd1});

    // 5: asynchronous reset while a record is pending
    trace_ready = 1'b0;
    push_rec(32'h60, 32'h0060_0013, 32'h1060);
    start_run(32'h60, 16'd3);
    for (int k = 0; k < 20 && !trace_valid; k++) begin
      @(posedge clk); #1;
    end
    chk("t5_valid", trace_valid, 1'b1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t5_async_reset", {int_o, entry_o, step_o, trace_valid, trace_pc,
        trace_ins, trace_wb, busy, done, retired}, '0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    trace_ready = 1'b1;
    push_rec(32'h100, 32'h0100_0013, 32'h1100);
    push_rec(32'h104, 32'h0104_0013, 32'h1104);
    push_run(16'd2, 16'd2, 16'd2);
    start_run(32'h100, 16'd2);
    wait_done("t5");
    chk("t5_rerun", {retired, entry_o}, {16'd2, 32'h100});

    // 6: ebreak as third instruction
    ebreak_pc = 32'h208;
    push_rec(32'h200, 32'h0200_0013, 32'h1200);
    push_rec(32'h204, 32'h0204_0013, 32'h1204);
    push_rec(32'h208, 32'h0010_0073, 32'h1208);
`ifdef HALT_ON_EBREAK_EN
    push_run(16'd3, 16'd3, 16'd2);
    start_run(32'h200, 16'd10);
    wait_done("t6");
    chk("t6_ebreak_halt", {done, retired}, {1'b1, 16'd3});
`else
    push_rec(32'h20C, 32'h020C_0013, 32'h120C);
    push_run(16'd4, 16'd4, 16'd2);
    start_run(32'h200, 16'd4);
    wait_done("t6");
    chk("t6_ebreak_ignored", {done, retired}, {1'b1, 16'd4});
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("trace_q_empty", exp_q.size(), 0);
    chk("run_q_empty", run_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
